// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier that drives an external ripple adder.
// Optional BUSY_ERR_EN adds a registered err pulse for starts issued while busy.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; product holds last result
// RUN   | one partial-product add and shift per cycle, WIDTH cycles
// DONE  | product valid, done pulses; start here chains a new run
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplr,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   adder_a,
   output logic [WIDTH-1:0]   adder_b,
   output logic               adder_cin,
   input  logic [WIDTH-1:0]   adder_sum,
   input  logic               adder_cout
`ifdef BUSY_ERR_EN
   ,
   output logic               err
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] mcand_r;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end
         end
         S_RUN: begin
            if (cnt == CNT_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy  = (state == S_RUN);
   assign ready = !busy;
   assign done  = (state == S_DONE);

   // Adder result and carry shift in from the top while q drains its consumed LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi  <= '0;
         q       <= '0;
         mcand_r <= '0;
         cnt     <= '0;
      end else if (load) begin
         mcand_r <= mcand;
         q       <= mplr;
         acc_hi  <= '0;
         cnt     <= '0;
      end else if (busy) begin
         {acc_hi, q} <= {adder_cout, adder_sum, q[WIDTH-1:1]};
         cnt         <= cnt + CW'(1);
      end
   end

   assign product   = {acc_hi, q};
   assign adder_a   = busy ? acc_hi : '0;
   assign adder_b   = (busy && q[0]) ? mcand_r : '0;
   assign adder_cin = 1'b0;

`ifdef BUSY_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= start & busy;
   end
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: driver queues a*b expectations, monitor checks on done.
// The external 4-bit ripple adder is modelled here as plain addition.
module tb_shift_add_multiplier;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] mcand;
   logic [3:0] mplr;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] product;
   logic [3:0] adder_a;
   logic [3:0] adder_b;
   logic       adder_cin;
   logic [3:0] adder_sum;
   logic       adder_cout;
`ifdef BUSY_ERR_EN
   logic       err;
`endif

   shift_add_multiplier #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mcand      (mcand),
      .mplr       (mplr),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .adder_a    (adder_a),
      .adder_b    (adder_b),
      .adder_cin  (adder_cin),
      .adder_sum  (adder_sum),
      .adder_cout (adder_cout)
`ifdef BUSY_ERR_EN
      ,
      .err        (err)
`endif
   );

   assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   int         last_done_cyc = -1;
   int         prev_done_cyc = -1;
   logic [7:0] exp_q[$];
   logic [7:0] hold_val;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Monitor: pops an expectation on every done and checks idle-side invariants.
   initial begin
      hold_val = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_val = 8'h00;
            continue;
         end
         check("adder_cin", 32'(adder_cin), 32'd0);
         if (!busy) begin
            check("adder_a_idle", 32'(adder_a), 32'd0);
            check("adder_b_idle", 32'(adder_b), 32'd0);
         end
         check("ready_vs_busy", 32'(ready), 32'(!busy));
         if (done) begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check("product", 32'(product), 32'(e));
               hold_val = e;
            end
         end else if (ready) begin
            check("product_hold", 32'(product), 32'(hold_val));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!ready) check("ready_timeout", 32'(ready), 32'd1);
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b, output int acc_cyc);
      int ea;
      int eb;
      wait_ready();
      ea = int'(a);
      eb = int'(b);
      start = 1'b1;
      mcand = a;
      mplr  = b;
      exp_q.push_back(8'(ea * eb));
      @(posedge clk);
      acc_cyc = cyc + 1;
      #1;
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      rst_n = 1'b0;
      start = 1'b0;
      mcand = 4'h0;
      mplr  = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_adder_a", 32'(adder_a), 32'd0);
      check("rst_adder_b", 32'(adder_b), 32'd0);
`ifdef BUSY_ERR_EN
      check("rst_err", 32'(err), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1: max operands and latency
      issue(4'hF, 4'hF, acc);
      drain();
      check("t1_latency", 32'(last_done_cyc - acc), 32'd4);

      // T2
      issue(4'hA, 4'h3, acc);
      drain();
      issue(4'h0, 4'h9, acc);
      drain();

      // T3: start pulsed during RUN is ignored
      issue(4'h7, 4'h5, acc);
      @(posedge clk);
      #1;
      start = 1'b1;
      mcand = 4'h1;
      mplr  = 4'h1;
      @(posedge clk);
      #1;
      start = 1'b0;
`ifdef BUSY_ERR_EN
      check("t3_err", 32'(err), 32'd1);
`endif
      check("t3_still_busy", 32'(busy), 32'd1);
      drain();

      // T4: reset in the second RUN cycle
      issue(4'h9, 4'hD, acc);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_ready", 32'(ready), 32'd1);
      check("t4_product", 32'(product), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      issue(4'h3, 4'h3, acc);
      drain();

      // T5: start held high chains two products
      wait_ready();
      start = 1'b1;
      mcand = 4'h2;
      mplr  = 4'h6;
      exp_q.push_back(8'h0C);
      @(posedge clk);
      #1;
      mcand = 4'hC;
      mplr  = 4'hB;
      exp_q.push_back(8'h84);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      drain();
      check("t5_interval", 32'(last_done_cyc - prev_done_cyc), 32'd5);

      // T6: exhaustive pairs with random gaps
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            issue(4'(a), 4'(b), acc);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
         end
      end
      drain();

      // Random operands, mostly back-to-back
      for (int i = 0; i < 60; i++) begin
         issue(4'($urandom), 4'($urandom), acc);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
